// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle control unit: states, opcodes,
// instruction classes and the mux select codes driven into the datapath.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILLEGAL
  } ins_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_S = 3'd1;
  localparam logic [2:0] EXT_B = 3'd2;
  localparam logic [2:0] EXT_U = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] Y_ALU = 2'd0;
  localparam logic [1:0] Y_MEM = 2'd1;
  localparam logic [1:0] Y_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  function automatic logic is_mem_class(input ins_class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/rv_ins_decode.sv
// Combinational opcode/funct decoder: instruction class, immediate format,
// ALU operation and legality.
module rv_ins_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ins_class_t cls,
  output logic [2:0] extend,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    cls    = CL_ILLEGAL;
    extend = EXT_I;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_R: begin
        cls    = CL_R;
        alu_op = {funct7_5, funct3};
      end
      OP_IMM: begin
        cls    = CL_IMM;
        // funct7[5] only distinguishes SRAI from SRLI; other immediates ignore it
        alu_op = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
      end
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE: begin
        cls    = CL_STORE;
        extend = EXT_S;
      end
      OP_BRANCH: begin
        cls    = CL_BRANCH;
        extend = EXT_B;
      end
      OP_JAL: begin
        cls    = CL_JAL;
        extend = EXT_J;
      end
      OP_JALR:   cls = CL_JALR;
      OP_LUI: begin
        cls    = CL_LUI;
        extend = EXT_U;
      end
      OP_AUIPC: begin
        cls    = CL_AUIPC;
        extend = EXT_U;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control sequencer FETCH->DECODE->COMPUTE->MEM->WB with
// memory-complete handshake, optional bus timeout and illegal-opcode trap.
module mc_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter bit          SKIP_MEM    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ins,
  input  logic            mem_done,
  input  logic            br_taken,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            ir_en,
  output logic            ma_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      extend,
  output logic            b_sel,
  output logic [3:0]      alu_op,
  output logic [1:0]      y_sel,
  output logic            rf_wr,
  output logic            illegal_ins,
  output logic            bus_err,
  output logic [2:0]      state_o
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t     state, nxt;
  logic [CW-1:0] cnt;
  ins_class_t cls;
  logic [2:0] dec_ext;
  logic [3:0] dec_alu;
  logic       legal;
  logic       waiting, timeout, dec_active;
  logic       unused_ins_bits;

  rv_ins_decode u_dec (
    .opcode   (ins[6:0]),
    .funct3   (ins[14:12]),
    .funct7_5 (ins[30]),
    .cls      (cls),
    .extend   (dec_ext),
    .alu_op   (dec_alu),
    .legal    (legal)
  );

  assign unused_ins_bits = ^{ins[XLEN-1:31], ins[29:15]};
  assign state_o = state;

  assign waiting = ((state == ST_FETCH) || (state == ST_MEM && is_mem_class(cls))) && !mem_done;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt == CW'(MEM_TIMEOUT - 1));
  assign dec_active = (state == ST_COMPUTE) || (state == ST_MEM) || (state == ST_WB);

  always_comb begin
    nxt         = state;
    pc_en       = 1'b0;
    pc_sel      = PC_PLUS4;
    ir_en       = 1'b0;
    ma_sel      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    extend      = dec_active ? dec_ext : '0;
    alu_op      = dec_active ? dec_alu : '0;
    b_sel       = dec_active && !(cls == CL_R || cls == CL_BRANCH);
    y_sel       = Y_ALU;
    rf_wr       = 1'b0;
    illegal_ins = 1'b0;
    bus_err     = 1'b0;
    case (state)
      ST_RESET: nxt = ST_FETCH;
      ST_FETCH: begin
        if (timeout) begin
          bus_err = 1'b1;
          nxt     = ST_FETCH;
        end else begin
          mem_rd = 1'b1;
          if (mem_done) begin
            ir_en = 1'b1;
            pc_en = 1'b1;
            nxt   = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          illegal_ins = 1'b1;
          nxt         = ST_FETCH;
        end else begin
          nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        case (cls)
          CL_BRANCH: begin
            pc_en  = br_taken;
            pc_sel = PC_IMM;
            nxt    = ST_FETCH;
          end
          CL_JAL: begin
            pc_en  = 1'b1;
            pc_sel = PC_IMM;
            nxt    = ST_WB;
          end
          CL_JALR: begin
            pc_en  = 1'b1;
            pc_sel = PC_ALU;
            nxt    = ST_WB;
          end
          CL_LOAD, CL_STORE: nxt = ST_MEM;
          default:           nxt = SKIP_MEM ? ST_WB : ST_MEM;
        endcase
      end
      ST_MEM: begin
        if (is_mem_class(cls)) begin
          ma_sel = 1'b1;
          if (timeout) begin
            bus_err = 1'b1;
            nxt     = ST_FETCH;
          end else begin
            mem_rd = (cls == CL_LOAD);
            mem_wr = (cls == CL_STORE);
            if (mem_done) nxt = (cls == CL_STORE) ? ST_FETCH : ST_WB;
          end
        end else begin
          nxt = ST_WB;
        end
      end
      ST_WB: begin
        rf_wr = (ins[11:7] != 5'd0);
        if (cls == CL_LOAD)                        y_sel = Y_MEM;
        else if (cls == CL_JAL || cls == CL_JALR) y_sel = Y_PC4;
        nxt = ST_FETCH;
      end
      default: nxt = ST_RESET;
    endcase
  end

  // Wait counter restarts whenever a wait state is (re)entered, including the
  // FETCH->FETCH retry after a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state || timeout)            cnt <= '0;
      else if (waiting && MEM_TIMEOUT != 0)  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: per-instruction reference
// sequences are queued by the stimulus and compared cycle by cycle.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n, mem_done, br_taken;
  logic [31:0] ins;
  logic        pc_en, ir_en, ma_sel, mem_rd, mem_wr, b_sel, rf_wr, illegal_ins, bus_err;
  logic [1:0]  pc_sel, y_sel;
  logic [2:0]  extend, state_o;
  logic [3:0]  alu_op;

  mc_ctrl_fsm #(.XLEN(32), .MEM_TIMEOUT(4), .SKIP_MEM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .mem_done(mem_done), .br_taken(br_taken),
    .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en), .ma_sel(ma_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .extend(extend), .b_sel(b_sel),
    .alu_op(alu_op), .y_sel(y_sel), .rf_wr(rf_wr), .illegal_ins(illegal_ins),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       ir_en, ma_sel, mem_rd, mem_wr;
    logic [2:0] ext;
    logic       b_sel;
    logic [3:0] alu_op;
    logic [1:0] y_sel;
    logic       rf_wr, ill, berr;
  } obs_t;

  localparam logic [2:0] S_RST = 3'd0, S_FET = 3'd1, S_DEC = 3'd2, S_CMP = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;
  localparam int C_R = 0, C_IMM = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6,
                 C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  logic [6:0] op_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  obs_t        expq[$];
  int unsigned nchecks = 0;
  int unsigned nerr    = 0;

  function automatic int cls_of(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (op_tab[i] == op) return i;
    return C_ILL;
  endfunction

  function automatic logic [2:0] ext_of(input int c);
    case (c)
      C_ST:           return 3'd1;
      C_BR:           return 3'd2;
      C_LUI, C_AUIPC: return 3'd3;
      C_JAL:          return 3'd4;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input int c, input logic [31:0] w);
    if (c == C_R) return {w[30], w[14:12]};
    if (c == C_IMM) return (w[14:12] == 3'b101) ? {w[30], w[14:12]} : {1'b0, w[14:12]};
    return 4'b0000;
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic [31:0] rand_ins(input int c);
    logic [31:0] w = $urandom;
    logic [6:0]  op;
    if (c == C_ILL) begin
      do op = 7'($urandom); while (cls_of(op) != C_ILL);
    end else begin
      op = op_tab[c];
    end
    w[6:0] = op;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic cyc(input logic rv, input logic md, input logic bt, input logic [31:0] iw, input obs_t e);
    @(posedge clk);
    #1;
    rst_n    = rv;
    mem_done = md;
    br_taken = bt;
    ins      = iw;
    expq.push_back(e);
  endtask

  // One instruction from FETCH to its last state; bt_force<0 means random branch outcome.
  task automatic run_ins(input logic [31:0] iw, input int fwait, input int mwait,
                         input bit stuck, input bit rst_mid, input int bt_force);
    obs_t e;
    int   c = cls_of(iw[6:0]);
    logic bt;
    for (int i = 0; i < fwait; i++) begin
      e = blank(S_FET); e.mem_rd = 1'b1;
      cyc(1'b1, 1'b0, 1'($urandom), iw, e);
    end
    e = blank(S_FET); e.mem_rd = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
    cyc(1'b1, 1'b1, 1'($urandom), iw, e);
    e = blank(S_DEC);
    e.ill = (c == C_ILL);
    cyc(1'b1, 1'($urandom), 1'($urandom), iw, e);
    if (c == C_ILL) return;
    bt = (bt_force < 0) ? 1'($urandom) : 1'(bt_force);
    e = blank(S_CMP);
    e.ext = ext_of(c); e.alu_op = alu_of(c, iw); e.b_sel = !(c == C_R || c == C_BR);
    if (c == C_BR)   begin e.pc_en = bt;   e.pc_sel = 2'd1; end
    if (c == C_JAL)  begin e.pc_en = 1'b1; e.pc_sel = 2'd1; end
    if (c == C_JALR) begin e.pc_en = 1'b1; e.pc_sel = 2'd2; end
    cyc(1'b1, 1'($urandom), bt, iw, e);
    if (c == C_BR) return;
    if (c == C_LD || c == C_ST) begin
      e = blank(S_MEM); e.ma_sel = 1'b1; e.mem_rd = (c == C_LD); e.mem_wr = (c == C_ST);
      if (rst_mid) begin
        cyc(1'b1, 1'b0, 1'b0, iw, e);
        cyc(1'b0, 1'b0, 1'b0, iw, blank(S_RST));
        cyc(1'b1, 1'b0, 1'b0, iw, blank(S_RST));
        return;
      end
      if (stuck) begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'($urandom), iw, e);
        e = blank(S_MEM); e.ma_sel = 1'b1; e.berr = 1'b1;
        cyc(1'b1, 1'b0, 1'($urandom), iw, e);
        return;
      end
      for (int i = 0; i < mwait; i++) cyc(1'b1, 1'b0, 1'($urandom), iw, e);
      cyc(1'b1, 1'b1, 1'($urandom), iw, e);
      if (c == C_ST) return;
    end
    e = blank(S_WB);
    e.rf_wr = (iw[11:7] != 5'd0);
    e.y_sel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    cyc(1'b1, 1'($urandom), 1'($urandom), iw, e);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{st: state_o, pc_en: pc_en, pc_sel: pc_sel, ir_en: ir_en, ma_sel: ma_sel,
              mem_rd: mem_rd, mem_wr: mem_wr, ext: extend, b_sel: b_sel, alu_op: alu_op,
              y_sel: y_sel, rf_wr: rf_wr, ill: illegal_ins, berr: bus_err};
        if (e.st != S_CMP) begin
          a.ext = '0; a.b_sel = 1'b0; a.alu_op = '0;
        end
        nchecks++;
        if (a !== e) begin
          nerr++;
          $display("FAIL cycle_obs t=%0t exp_state=%0d got=%h exp=%h", $time, e.st, a, e);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; mem_done = 1'b0; br_taken = 1'b0; ins = '0;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, blank(S_RST));
    cyc(1'b0, 1'b1, 1'b1, 32'h0, blank(S_RST));
    cyc(1'b1, 1'b0, 1'b0, 32'h0, blank(S_RST));
    run_ins(32'h002081B3, 0, 0, 1'b0, 1'b0, -1);
    run_ins(32'h0080A283, 0, 3, 1'b0, 1'b0, -1);
    run_ins(32'h00208463, 1, 0, 1'b0, 1'b0, 1);
    run_ins(32'h00208463, 0, 0, 1'b0, 1'b0, 0);
    run_ins(32'h0000007F, 0, 0, 1'b0, 1'b0, -1);
    run_ins(32'h0020A023, 0, 0, 1'b1, 1'b0, -1);
    run_ins(32'h0080A283, 2, 0, 1'b0, 1'b1, -1);
    run_ins(32'h0020A023, 0, 2, 1'b0, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 9);
      run_ins(rand_ins(c), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, -1);
    end
    repeat (3) @(negedge clk);
    nchecks++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL queue_drain got=%0d pending required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
